// File: rtl/dual_port_mem_model_if.sv
// Signal bundle between the core's fetch/data ports and the memory responder.
// Handshake: a request is taken on a rising edge where its strobe and accept are
// both high; valid/ack pulse for exactly one cycle per response, in request order.
interface dual_port_mem_model_if #(
  parameter int TAG_W = 11
);
  logic             mem_i_rd_w;
  logic [31:0]      mem_i_pc_w;
  logic             mem_i_accept_w;
  logic             mem_i_valid_w;
  logic [31:0]      mem_i_inst_w;
  logic             mem_i_error_w;

  logic [31:0]      mem_d_addr_w;
  logic [31:0]      mem_d_data_wr_w;
  logic             mem_d_rd_w;
  logic [3:0]       mem_d_wr_w;
  logic             mem_d_flush_w;
  logic             mem_d_invalidate_w;
  logic             mem_d_writeback_w;
  logic [TAG_W-1:0] mem_d_req_tag_w;
  logic             mem_d_accept_w;
  logic             mem_d_ack_w;
  logic [31:0]      mem_d_data_rd_w;
  logic             mem_d_error_w;
  logic [TAG_W-1:0] mem_d_resp_tag_w;

  modport master (
    output mem_i_rd_w, mem_i_pc_w,
    output mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
    output mem_d_flush_w, mem_d_invalidate_w, mem_d_writeback_w, mem_d_req_tag_w,
    input  mem_i_accept_w, mem_i_valid_w, mem_i_inst_w, mem_i_error_w,
    input  mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w, mem_d_error_w, mem_d_resp_tag_w
  );

  modport slave (
    input  mem_i_rd_w, mem_i_pc_w,
    input  mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
    input  mem_d_flush_w, mem_d_invalidate_w, mem_d_writeback_w, mem_d_req_tag_w,
    output mem_i_accept_w, mem_i_valid_w, mem_i_inst_w, mem_i_error_w,
    output mem_d_accept_w, mem_d_ack_w, mem_d_data_rd_w, mem_d_error_w, mem_d_resp_tag_w
  );
endinterface

// File: rtl/dual_port_mem_model.sv
// Dual-port memory responder: fetch and data ports share one word array, each port
// has an in-order latency queue. Optional random stalls with MEM_MODEL_STALL_EN.
module dual_port_mem_model_fifo #(
  parameter int W       = 33,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic [7:0]   now,
  output logic         room,
  output logic         pop,
  output logic [W-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [W-1:0]  data_q  [DEPTH];
  logic [7:0]    stamp_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [7:0]    age;

  // Modulo-256 age stays correct across counter wrap since entries never wait that long.
  assign age       = now - stamp_q[head];
  assign pop       = (count != '0) && (age >= 8'(LATENCY));
  assign room      = (count < FULL) || pop;
  assign head_data = data_q[head];

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail]  <= push_data;
      stamp_q[tail] <= now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule

module dual_port_mem_model #(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 1,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 11
) (
  input logic                  clk,
  input logic                  rst,
  dual_port_mem_model_if.slave bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int IW = 33;
  localparam int DW = 33 + TAG_W;
  localparam logic [31:0] WORDS = MEM_WORDS;

  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  now;

  always_ff @(posedge clk) begin
    if (rst) now <= '0;
    else     now <= now + 8'd1;
  end

  logic          i_bad, i_take, i_room, i_pop, i_fire, i_stall;
  logic [31:0]   i_rdata;
  logic [IW-1:0] i_head;

  assign i_bad   = (bus.mem_i_pc_w[1:0] != 2'b00) || ({2'b00, bus.mem_i_pc_w[31:2]} >= WORDS);
  assign i_rdata = i_bad ? 32'h0 : mem[bus.mem_i_pc_w[AW+1:2]];
  assign bus.mem_i_accept_w = i_room & ~i_stall & ~rst;
  assign i_take  = bus.mem_i_rd_w & i_room & ~i_stall & ~rst;

  dual_port_mem_model_fifo #(.W(IW), .DEPTH(DEPTH), .LATENCY(LATENCY)) i_q (
    .clk(clk), .rst(rst), .push(i_take), .push_data({i_rdata, i_bad}),
    .now(now), .room(i_room), .pop(i_pop), .head_data(i_head)
  );

  assign i_fire = i_pop & ~rst;
  assign bus.mem_i_valid_w = i_fire;
  assign bus.mem_i_inst_w  = i_fire ? i_head[IW-1:1] : 32'h0;
  assign bus.mem_i_error_w = i_fire & i_head[0];

  logic          d_wr_any, d_rw, d_mnt, d_bad, d_err, d_take, d_room, d_pop, d_fire, d_stall;
  logic [31:0]   d_rdata;
  logic [AW-1:0] d_idx;
  logic [DW-1:0] d_head;

  assign d_wr_any = |bus.mem_d_wr_w;
  assign d_rw     = bus.mem_d_rd_w | d_wr_any;
  assign d_mnt    = bus.mem_d_flush_w | bus.mem_d_invalidate_w | bus.mem_d_writeback_w;
  assign d_idx    = bus.mem_d_addr_w[AW+1:2];
  assign d_bad    = (bus.mem_d_addr_w[1:0] != 2'b00) || ({2'b00, bus.mem_d_addr_w[31:2]} >= WORDS);
  // Maintenance ops never fault; only real reads/writes are address-checked.
  assign d_err    = d_rw & (d_bad | (bus.mem_d_rd_w & d_wr_any));
  assign d_rdata  = (bus.mem_d_rd_w & ~d_err) ? mem[d_idx] : 32'h0;
  assign bus.mem_d_accept_w = d_room & ~d_stall & ~rst;
  assign d_take   = (d_rw | d_mnt) & d_room & ~d_stall & ~rst;

  always_ff @(posedge clk) begin
    if (d_take & d_wr_any & ~d_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wr_w[b]) mem[d_idx][8*b +: 8] <= bus.mem_d_data_wr_w[8*b +: 8];
      end
    end
  end

  dual_port_mem_model_fifo #(.W(DW), .DEPTH(DEPTH), .LATENCY(LATENCY)) d_q (
    .clk(clk), .rst(rst), .push(d_take),
    .push_data({d_rdata, d_err, bus.mem_d_req_tag_w}),
    .now(now), .room(d_room), .pop(d_pop), .head_data(d_head)
  );

  assign d_fire = d_pop & ~rst;
  assign bus.mem_d_ack_w      = d_fire;
  assign bus.mem_d_data_rd_w  = d_fire ? d_head[DW-1 -: 32] : 32'h0;
  assign bus.mem_d_error_w    = d_fire & d_head[TAG_W];
  assign bus.mem_d_resp_tag_w = d_fire ? d_head[TAG_W-1:0] : '0;

`ifdef MEM_MODEL_STALL_EN
  logic [15:0] i_lfsr, d_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_lfsr <= 16'hACE1;
      d_lfsr <= 16'h1D2B;
    end else begin
      i_lfsr <= {i_lfsr[0] ^ i_lfsr[2] ^ i_lfsr[3] ^ i_lfsr[5], i_lfsr[15:1]};
      d_lfsr <= {d_lfsr[0] ^ d_lfsr[2] ^ d_lfsr[3] ^ d_lfsr[5], d_lfsr[15:1]};
    end
  end

  assign i_stall = i_lfsr[0];
  assign d_stall = d_lfsr[0];
`else
  assign i_stall = 1'b0;
  assign d_stall = 1'b0;
`endif
endmodule
